// File: rtl/rx_inband_pkg.sv
// rx_inband_pkg: packet geometry constants, packetizer FSM state type and
// header word helpers shared by the inband receive-side packet builder.
package rx_inband_pkg;

    localparam logic [8:0] PKT_WORDS     = 9'd256;
    localparam logic [8:0] HDR_WORDS     = 9'd4;
    localparam logic [8:0] PAYLOAD_WORDS = 9'd252;
    localparam logic [6:0] SAMPS_PER_PKT = 7'd126;
    localparam logic [8:0] PAYLOAD_BYTES = 9'd504;

    // word index within an outgoing packet, wide enough to hold PKT_WORDS
    typedef logic [8:0] word_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CMD,
        ST_PAD
    } rx_state_t;

    // w0: start, end, overrun, reserved, payload byte count
    function automatic logic [15:0] hdr_word0(input logic ovr);
        return {1'b1, 1'b1, ovr, 4'b0000, PAYLOAD_BYTES};
    endfunction

    // w1: rssi low bits, reserved, channel id
    function automatic logic [15:0] hdr_word1(input logic [5:0] rssi_lo, input logic [4:0] chan);
        return {rssi_lo, 5'b00000, chan};
    endfunction

endpackage

// File: rtl/rx_sample_fifo.sv
// rx_sample_fifo: synchronous show-ahead FIFO with occupancy count.
// Used for both the {I,Q} sample store and the packet timestamp store.
// DEPTH must be a power of two (pointers wrap naturally).
module rx_sample_fifo
    import rx_inband_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wr,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_rd,
    output logic [WIDTH-1:0]        o_rdata,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_wr & ~o_full;
    assign w_pop   = i_rd & ~o_empty;
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    // storage array, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rx_packet_builder.sv
// rx_packet_builder: receive-side inband packetizer. Buffers one channel's
// I/Q samples, timestamps each 126-sample group, and emits 256-word packets
// (4 header + 252 payload words). Command-reply packets from the command
// reader are forwarded and zero-padded to full packet length.
// Build option: define RX_RSSI_EN to place rssi[5:0] in header word 1.
module rx_packet_builder
    import rx_inband_pkg::*;
#(
    parameter logic [4:0]  CHAN_ID    = 5'd0,
    parameter int unsigned SAMP_DEPTH = 512,
    parameter int unsigned TS_DEPTH   = 4
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic        rxstrobe,
    input  logic [15:0] rx_i,
    input  logic [15:0] rx_q,
    input  logic [31:0] adc_time,
    input  logic [31:0] rssi,
    input  logic [15:0] rx_databus,
    input  logic        rx_WR,
    input  logic        rx_WR_done,
    output logic        rx_WR_enabled,
    input  logic        out_have_space,
    output logic [15:0] out_data,
    output logic        out_WR,
    output logic        overrun,
    output logic        cmd_overflow
);

    localparam int unsigned SCW = $clog2(SAMP_DEPTH) + 1;
    localparam int unsigned TCW = $clog2(TS_DEPTH) + 1;

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    word_idx_t   r_idx;
    word_idx_t   w_idx_nxt;
    logic [15:0] r_out_data;
    logic [15:0] w_out_data_nxt;
    logic        r_out_wr;
    logic        w_out_wr_nxt;
    logic        r_wr_enabled;
    logic        w_wr_enabled_nxt;
    logic        r_overrun;
    logic        r_cmd_ovf;
    logic [6:0]  r_wcnt;

    logic        w_drop;
    logic        w_samp_push;
    logic        w_ts_push;
    logic        w_samp_pop;
    logic        w_ts_pop;
    logic        w_ovr_clear;
    logic        w_cmd_ovf_set;
    logic        w_data_ready;

    logic [31:0]    w_samp_rdata;
    logic [31:0]    w_ts_rdata;
    logic [SCW-1:0] w_samp_count;
    logic           w_samp_full;
    logic           w_unused_samp_empty;
    logic [TCW-1:0] w_unused_ts_count;
    logic           w_ts_full;
    logic           w_ts_empty;
    logic [15:0]    w_hdr_w1;
    logic           w_unused_rssi;

`ifdef RX_RSSI_EN
    assign w_hdr_w1      = hdr_word1(rssi[5:0], CHAN_ID);
    assign w_unused_rssi = ^rssi[31:6];
`else
    assign w_hdr_w1      = hdr_word1(6'b000000, CHAN_ID);
    assign w_unused_rssi = ^rssi;
`endif

    // A sample that would start a packet also needs a timestamp slot.
    assign w_drop      = rxstrobe & (w_samp_full | ((r_wcnt == '0) & w_ts_full));
    assign w_samp_push = rxstrobe & ~w_drop;
    assign w_ts_push   = w_samp_push & (r_wcnt == '0);

    assign w_data_ready = (w_samp_count >= SCW'(SAMPS_PER_PKT)) & ~w_ts_empty;

    rx_sample_fifo #(
        .WIDTH (32),
        .DEPTH (SAMP_DEPTH)
    ) u_samp_fifo (
        .i_clk   (txclk),
        .i_reset (reset),
        .i_wr    (w_samp_push),
        .i_wdata ({rx_i, rx_q}),
        .i_rd    (w_samp_pop),
        .o_rdata (w_samp_rdata),
        .o_count (w_samp_count),
        .o_full  (w_samp_full),
        .o_empty (w_unused_samp_empty)
    );

    rx_sample_fifo #(
        .WIDTH (32),
        .DEPTH (TS_DEPTH)
    ) u_ts_fifo (
        .i_clk   (txclk),
        .i_reset (reset),
        .i_wr    (w_ts_push),
        .i_wdata (adc_time),
        .i_rd    (w_ts_pop),
        .o_rdata (w_ts_rdata),
        .o_count (w_unused_ts_count),
        .o_full  (w_ts_full),
        .o_empty (w_ts_empty)
    );

    // write-side packet position and sticky status flags
    always_ff @(posedge txclk) begin
        if (reset) begin
            r_wcnt    <= '0;
            r_overrun <= 1'b0;
            r_cmd_ovf <= 1'b0;
        end else begin
            if (w_samp_push) begin
                r_wcnt <= (r_wcnt == SAMPS_PER_PKT - 7'd1) ? '0 : r_wcnt + 7'd1;
            end
            // a drop in the same cycle as the header clear keeps the flag set
            r_overrun <= w_drop | (r_overrun & ~w_ovr_clear);
            r_cmd_ovf <= r_cmd_ovf | w_cmd_ovf_set;
        end
    end

    // FSM state, word index and registered output word
    always_ff @(posedge txclk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_out_data   <= '0;
            r_out_wr     <= 1'b0;
            r_wr_enabled <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_wr     <= w_out_wr_nxt;
            r_wr_enabled <= w_wr_enabled_nxt;
        end
    end

    // next state, next output word and FIFO pops
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_out_data_nxt = '0;
        w_out_wr_nxt   = 1'b0;
        w_samp_pop     = 1'b0;
        w_ts_pop       = 1'b0;
        w_ovr_clear    = 1'b0;
        w_cmd_ovf_set  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_data_ready & out_have_space) begin
                    w_out_data_nxt = hdr_word0(r_overrun);
                    w_out_wr_nxt   = 1'b1;
                    w_ovr_clear    = 1'b1;
                    w_idx_nxt      = 9'd1;
                    w_state_nxt    = ST_HDR;
                end else if (rx_WR & r_wr_enabled) begin
                    w_out_data_nxt = rx_databus;
                    w_out_wr_nxt   = 1'b1;
                    w_idx_nxt      = 9'd1;
                    w_state_nxt    = ST_CMD;
                end
            end

            ST_HDR: begin
                w_out_wr_nxt = 1'b1;
                w_idx_nxt    = r_idx + 9'd1;
                if (r_idx == 9'd1) begin
                    w_out_data_nxt = w_hdr_w1;
                end else if (r_idx == 9'd2) begin
                    w_out_data_nxt = w_ts_rdata[15:0];
                end else begin
                    w_out_data_nxt = w_ts_rdata[31:16];
                end
                if (r_idx == HDR_WORDS - 9'd1) begin
                    w_ts_pop    = 1'b1;
                    w_state_nxt = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                // even index carries I, odd index carries Q and retires the entry
                w_out_wr_nxt   = 1'b1;
                w_idx_nxt      = r_idx + 9'd1;
                w_out_data_nxt = r_idx[0] ? w_samp_rdata[15:0] : w_samp_rdata[31:16];
                w_samp_pop     = r_idx[0];
                if (r_idx == HDR_WORDS + PAYLOAD_WORDS - 9'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_CMD: begin
                if (rx_WR) begin
                    if (r_idx < PKT_WORDS) begin
                        w_out_data_nxt = rx_databus;
                        w_out_wr_nxt   = 1'b1;
                        w_idx_nxt      = r_idx + 9'd1;
                    end else begin
                        w_cmd_ovf_set = 1'b1;
                    end
                end
                if (rx_WR_done) begin
                    w_state_nxt = (w_idx_nxt < PKT_WORDS) ? ST_PAD : ST_IDLE;
                end
            end

            ST_PAD: begin
                w_out_wr_nxt = 1'b1;
                w_idx_nxt    = r_idx + 9'd1;
                if (r_idx == PKT_WORDS - 9'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // grant held through CMD; fresh grants only after a full idle cycle
        w_wr_enabled_nxt = (w_state_nxt == ST_CMD) |
                           ((r_state == ST_IDLE) & (w_state_nxt == ST_IDLE) &
                            out_have_space & ~w_data_ready);
    end

    assign out_data      = r_out_data;
    assign out_WR        = r_out_wr;
    assign rx_WR_enabled = r_wr_enabled;
    assign overrun       = r_overrun;
    assign cmd_overflow  = r_cmd_ovf;

endmodule
